score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/dino_pkg.sv | 28 ++
 rtl/bcd_digit.sv | 34 +++
 rtl/score_keeper.sv | 158 +++++++++++++++
 tb/tb_score_keeper.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dino_pkg.sv
// -----------------------------------------------------------------------------
// dino_pkg -- shared types and constants for the score keeping slice.
//   score_state_t : score keeper state (IDLE / RUNNING / OVER)
//   BCD_DIGITS    : number of BCD digits in a score
//   BCD_WIDTH     : bit width of a packed BCD score
//   bcd_to_bin()  : packed BCD -> binary, used on parameters at elaboration
// -----------------------------------------------------------------------------
package dino_pkg;

   localparam int unsigned BCD_DIGITS = 4;
   localparam int unsigned BCD_WIDTH  = 4 * BCD_DIGITS;

   typedef enum logic [1:0] {
      IDLE,
      RUNNING,
      OVER
   } score_state_t;

   function automatic logic [15:0] bcd_to_bin(input logic [BCD_WIDTH-1:0] bcd);
      logic [15:0] acc;
      acc = '0;
      for (int unsigned i = BCD_DIGITS; i > 0; i--) begin
         acc = (acc * 16'd10) + {12'd0, bcd[4*(i-1) +: 4]};
      end
      return acc;
   endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit -- one registered BCD digit of a ripple-carry BCD counter.
//   clk       : clock, rising edge
//   reset     : synchronous active-high reset, digit -> 0
//   clear     : synchronous clear, digit -> 0
//   inc_in    : increment request from the lower digit (or the point event)
//   sat       : hold at current value (whole counter is at all-nines)
//   digit     : current digit value 0..9
//   carry_out : this digit wraps 9 -> 0 on an increment (ignores sat, so the
//               top digit's carry_out doubles as the overflow indicator)
// -----------------------------------------------------------------------------
module bcd_digit (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       inc_in,
   input  logic       sat,
   output logic [3:0] digit,
   output logic       carry_out
);

   always_comb begin
      carry_out = inc_in && (digit == 4'd9);
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         digit <= '0;
      end else if (inc_in && !sat) begin
         digit <= carry_out ? 4'd0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/score_keeper.sv
// -----------------------------------------------------------------------------
// score_keeper -- game score, difficulty level and optional high score.
// Optional feature macro: SCORE_KEEPER_HIGH_SCORE_EN (high-score register and
// comparator; when undefined both high-score outputs are tied to 0).
//   clk              : clock, rising edge
//   reset            : synchronous active-high reset, clears everything
//   game_tick[1:0]   : tick phases; only [1] advances the prescaler
//   game_start_pulse : start/restart from IDLE or OVER
//   game_over_pulse  : crash, RUNNING -> OVER (wins over start and over a point)
//   score_bcd        : current score, 4 BCD digits, saturates at 9999
//   high_score_bcd   : best finished score
//   speed_level      : difficulty 0..7, steps at every SPEEDUP_POINTS_BCD points
//   milestone_pulse  : one cycle after each speed_level step
//   new_high_score   : last finished game set a new record
//   scoring          : state is RUNNING
// -----------------------------------------------------------------------------
module score_keeper
   import dino_pkg::*;
#(
   parameter int unsigned TICKS_PER_POINT    = 6,
   parameter logic [15:0] SPEEDUP_POINTS_BCD = 16'h0100
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [1:0]           game_tick,
   input  logic                 game_start_pulse,
   input  logic                 game_over_pulse,
   output logic [BCD_WIDTH-1:0] score_bcd,
   output logic [BCD_WIDTH-1:0] high_score_bcd,
   output logic [2:0]           speed_level,
   output logic                 milestone_pulse,
   output logic                 new_high_score,
   output logic                 scoring
);

   localparam logic [7:0]  PRESCALE_MAX = 8'(TICKS_PER_POINT - 1);
   localparam logic [15:0] SPEEDUP_BIN  = bcd_to_bin(SPEEDUP_POINTS_BCD);

   score_state_t state, next_state;

   logic                  start_go;
   logic                  over_go;
   logic                  tick_adv;
   logic                  point_due;
   logic                  score_inc;
   logic                  milestone_due;
   logic [7:0]            prescaler;
   logic [15:0]           pts_since;
   logic [BCD_DIGITS:0]   carry;

   // ---------------- FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE, OVER: begin
            if (game_start_pulse && !game_over_pulse) next_state = RUNNING;
         end
         RUNNING: begin
            if (game_over_pulse) next_state = OVER;
         end
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      scoring  = (state == RUNNING);
      start_go = (state != RUNNING) && game_start_pulse && !game_over_pulse;
      over_go  = (state == RUNNING) && game_over_pulse;
      tick_adv = (state == RUNNING) && game_tick[1] && !game_over_pulse;
   end

   // ---------------- prescaler ----------------
   always_ff @(posedge clk) begin
      if (reset || start_go) begin
         prescaler <= '0;
      end else if (tick_adv) begin
         prescaler <= (prescaler == PRESCALE_MAX) ? 8'd0 : prescaler + 8'd1;
      end
   end

   always_comb begin
      point_due = tick_adv && (prescaler == PRESCALE_MAX);
   end

   // ---------------- BCD score chain ----------------
   // The top digit's carry_out flags an increment attempted at all-nines; it
   // feeds back as sat so every digit holds and 9999 is sticky.
   assign carry[0] = point_due;

   for (genvar i = 0; i < BCD_DIGITS; i++) begin : g_digit
      bcd_digit u_digit (
         .clk       (clk),
         .reset     (reset),
         .clear     (start_go),
         .inc_in    (carry[i]),
         .sat       (carry[BCD_DIGITS]),
         .digit     (score_bcd[4*i +: 4]),
         .carry_out (carry[i+1])
      );
   end

   always_comb begin
      score_inc     = point_due && !carry[BCD_DIGITS];
      milestone_due = score_inc && (pts_since == SPEEDUP_BIN - 16'd1);
   end

   // ---------------- speed level ----------------
   // Score only climbs from 0 within a game, so a binary count of points since
   // the last multiple stands in for "score mod SPEEDUP == 0".
   always_ff @(posedge clk) begin
      if (reset || start_go) begin
         pts_since <= '0;
      end else if (score_inc) begin
         pts_since <= milestone_due ? 16'd0 : pts_since + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || start_go) begin
         speed_level     <= '0;
         milestone_pulse <= 1'b0;
      end else begin
         milestone_pulse <= 1'b0;
         if (milestone_due && (speed_level != 3'd7)) begin
            speed_level     <= speed_level + 3'd1;
            milestone_pulse <= 1'b1;
         end
      end
   end

   // ---------------- high score ----------------
`ifdef SCORE_KEEPER_HIGH_SCORE_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         high_score_bcd <= '0;
         new_high_score <= 1'b0;
      end else if (start_go) begin
         new_high_score <= 1'b0;
      end else if (over_go && (score_bcd > high_score_bcd)) begin
         // Packed BCD compares correctly as a plain unsigned number.
         high_score_bcd <= score_bcd;
         new_high_score <= 1'b1;
      end
   end
`else
   assign high_score_bcd = '0;
   assign new_high_score = 1'b0;
`endif

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

   localparam int S_IDLE = 0;
   localparam int S_RUN  = 1;
   localparam int S_OVER = 2;

`ifdef SCORE_KEEPER_HIGH_SCORE_EN
   localparam bit HS_EN = 1'b1;
`else
   localparam bit HS_EN = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst  [2];
   logic [1:0]  tick [2];
   logic        st   [2];
   logic        ov   [2];
   logic [15:0] sc   [2];
   logic [15:0] hs   [2];
   logic [2:0]  lv   [2];
   logic        mp   [2];
   logic        nh   [2];
   logic        sg   [2];

   score_keeper #(.TICKS_PER_POINT(6), .SPEEDUP_POINTS_BCD(16'h0100)) u_dut (
      .clk(clk), .reset(rst[0]), .game_tick(tick[0]),
      .game_start_pulse(st[0]), .game_over_pulse(ov[0]),
      .score_bcd(sc[0]), .high_score_bcd(hs[0]), .speed_level(lv[0]),
      .milestone_pulse(mp[0]), .new_high_score(nh[0]), .scoring(sg[0])
   );

   score_keeper #(.TICKS_PER_POINT(1), .SPEEDUP_POINTS_BCD(16'h0150)) u_fast (
      .clk(clk), .reset(rst[1]), .game_tick(tick[1]),
      .game_start_pulse(st[1]), .game_over_pulse(ov[1]),
      .score_bcd(sc[1]), .high_score_bcd(hs[1]), .speed_level(lv[1]),
      .milestone_pulse(mp[1]), .new_high_score(nh[1]), .scoring(sg[1])
   );

   // ---------------- behavioural model ----------------
   int m_state [2];
   int m_score [2];
   int m_ticks [2];
   int m_level [2];
   int m_high  [2];
   bit m_newhi [2];
   bit m_pulse [2];

   int compared   = 0;
   int mismatched = 0;
   bit checking   = 1'b0;

   function automatic int tpp_of(input int k);
      return (k == 0) ? 6 : 1;
   endfunction

   function automatic int spd_of(input int k);
      return (k == 0) ? 100 : 150;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      logic [15:0] r;
      r[15:12] = 4'((v / 1000) % 10);
      r[11:8]  = 4'((v / 100) % 10);
      r[7:4]   = 4'((v / 10) % 10);
      r[3:0]   = 4'(v % 10);
      return r;
   endfunction

   task automatic model_step(input int k);
      int lvl;
      if (rst[k]) begin
         m_state[k] = S_IDLE; m_score[k] = 0; m_ticks[k] = 0; m_level[k] = 0;
         m_high[k] = 0; m_newhi[k] = 1'b0; m_pulse[k] = 1'b0;
      end else begin
         m_pulse[k] = 1'b0;
         if (m_state[k] == S_RUN) begin
            if (ov[k]) begin
               m_state[k] = S_OVER;
               if (HS_EN && (m_score[k] > m_high[k])) begin
                  m_high[k] = m_score[k];
                  m_newhi[k] = 1'b1;
               end
            end else if (tick[k][1]) begin
               m_ticks[k]++;
               if (m_ticks[k] == tpp_of(k)) begin
                  m_ticks[k] = 0;
                  if (m_score[k] < 9999) begin
                     m_score[k]++;
                     lvl = m_score[k] / spd_of(k);
                     if (lvl > 7) lvl = 7;
                     if (lvl != m_level[k]) m_pulse[k] = 1'b1;
                     m_level[k] = lvl;
                  end
               end
            end
         end else if (st[k] && !ov[k]) begin
            m_state[k] = S_RUN; m_score[k] = 0; m_ticks[k] = 0;
            m_level[k] = 0; m_newhi[k] = 1'b0;
         end
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k);
   end

   task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s[%0d] t=%0t: got %h expected %h", name, k, $time, act, exp);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (checking) begin
         for (int k = 0; k < 2; k++) begin
            chk("score",     k, sc[k], to_bcd(m_score[k]));
            chk("high",      k, hs[k], to_bcd(m_high[k]));
            chk("level",     k, 16'(lv[k]), 16'(m_level[k]));
            chk("milestone", k, 16'(mp[k]), 16'(m_pulse[k]));
            chk("newhigh",   k, 16'(nh[k]), 16'(m_newhi[k]));
            chk("scoring",   k, 16'(sg[k]), 16'(m_state[k] == S_RUN));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic pair(input int k, input bit over_on_t1);
      tick[k] = 2'b01;
      cyc();
      tick[k] = 2'b10;
      ov[k]   = over_on_t1;
      cyc();
      tick[k] = 2'b00;
      ov[k]   = 1'b0;
   endtask

   task automatic start(input int k);
      st[k] = 1'b1;
      cyc();
      st[k] = 1'b0;
   endtask

   task automatic do_reset(input int k);
      rst[k] = 1'b1;
      cyc();
      rst[k] = 1'b0;
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; tick[k] = 2'b00; st[k] = 1'b0; ov[k] = 1'b0;
         m_state[k] = S_IDLE; m_score[k] = 0; m_ticks[k] = 0; m_level[k] = 0;
         m_high[k] = 0; m_newhi[k] = 1'b0; m_pulse[k] = 1'b0;
      end
      cyc();
      checking = 1'b1;
      cyc();
      rst[0] = 1'b0;
      rst[1] = 1'b0;

      // reset state
      chk("rst_score",   0, sc[0], 16'h0000);
      chk("rst_level",   0, 16'(lv[0]), 16'd0);
      chk("rst_scoring", 0, 16'(sg[0]), 16'd0);

      // basic scoring: 12 tick pairs at 6 ticks/point -> 2 points
      start(0);
      chk("start_scoring", 0, 16'(sg[0]), 16'd1);
      repeat (12) pair(0, 1'b0);
      chk("basic_score", 0, sc[0], 16'h0002);
      chk("model_pin",   0, 16'(m_score[0]), 16'd2);

      // BCD carry 0099 -> 0100 with milestone
      repeat (97 * 6) pair(0, 1'b0);
      chk("pre_carry", 0, sc[0], 16'h0099);
      chk("pre_level", 0, 16'(lv[0]), 16'd0);
      repeat (5) pair(0, 1'b0);
      chk("prescale_hold", 0, sc[0], 16'h0099);
      pair(0, 1'b0);
      chk("carry_score", 0, sc[0], 16'h0100);
      chk("carry_level", 0, 16'(lv[0]), 16'd1);
      chk("carry_pulse", 0, 16'(mp[0]), 16'd1);
      cyc();
      chk("pulse_width", 0, 16'(mp[0]), 16'd0);

      // collision at 0041: game over wins, point dropped
      do_reset(0);
      start(0);
      repeat (41 * 6 + 5) pair(0, 1'b0);
      pair(0, 1'b1);
      chk("coll_score",   0, sc[0], 16'h0041);
      chk("coll_scoring", 0, 16'(sg[0]), 16'd0);
      chk("coll_high",    0, hs[0], HS_EN ? 16'h0041 : 16'h0000);
      chk("coll_newhigh", 0, 16'(nh[0]), HS_EN ? 16'd1 : 16'd0);

      // game over while OVER ignored; start+over together stays OVER
      ov[0] = 1'b1; cyc(); ov[0] = 1'b0;
      st[0] = 1'b1; ov[0] = 1'b1; cyc(); st[0] = 1'b0; ov[0] = 1'b0;
      chk("start_over_tie", 0, 16'(sg[0]), 16'd0);

      // equal score is not a record; restart clears score
      start(0);
      chk("restart_score",   0, sc[0], 16'h0000);
      chk("restart_newhigh", 0, 16'(nh[0]), 16'd0);
      repeat (41 * 6) pair(0, 1'b0);
      ov[0] = 1'b1; cyc(); ov[0] = 1'b0;
      chk("equal_score",   0, sc[0], 16'h0041);
      chk("equal_high",    0, hs[0], HS_EN ? 16'h0041 : 16'h0000);
      chk("equal_newhigh", 0, 16'(nh[0]), 16'd0);

      // mid-game reset at 0230
      start(0);
      repeat (230 * 6) pair(0, 1'b0);
      chk("mid_score", 0, sc[0], 16'h0230);
      chk("mid_level", 0, 16'(lv[0]), 16'd2);
      do_reset(0);
      chk("mrst_score",   0, sc[0], 16'h0000);
      chk("mrst_high",    0, hs[0], 16'h0000);
      chk("mrst_level",   0, 16'(lv[0]), 16'd0);
      chk("mrst_pulse",   0, 16'(mp[0]), 16'd0);
      chk("mrst_newhigh", 0, 16'(nh[0]), 16'd0);
      chk("mrst_scoring", 0, 16'(sg[0]), 16'd0);

      // saturation on the 1-tick-per-point instance
      start(1);
      tick[1] = 2'b11;
      repeat (9999) cyc();
      chk("sat_reach", 1, sc[1], 16'h9999);
      chk("sat_level", 1, 16'(lv[1]), 16'd7);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("sat_hold",  1, sc[1], 16'h9999);
         chk("sat_pulse", 1, 16'(mp[1]), 16'd0);
      end
      tick[1] = 2'b00;
      chk("sat_model_pin", 1, 16'(m_score[1]), 16'd9999);

      // randomized phase, checked every cycle against the model
      for (int n = 0; n < 5000; n++) begin
         tick[0] = 2'($urandom_range(0, 3));
         st[0]   = ($urandom_range(0, 15) == 0);
         ov[0]   = ($urandom_range(0, 63) == 0);
         rst[0]  = ($urandom_range(0, 999) == 0);
         tick[1] = 2'($urandom_range(0, 3));
         st[1]   = ($urandom_range(0, 15) == 0);
         ov[1]   = ($urandom_range(0, 511) == 0);
         rst[1]  = ($urandom_range(0, 1999) == 0);
         cyc();
      end
      for (int k = 0; k < 2; k++) begin
         tick[k] = 2'b00; st[k] = 1'b0; ov[k] = 1'b0; rst[k] = 1'b0;
      end
      cyc();
      @(negedge clk);
      #1;
      checking = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
